dht_multi_reader: RTL and testbench
===================================

DHT_MULTI_READER -- requirements
Module: dht_multi_reader

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz; SHALL be an integer multiple of 1_000_000.
REQ-002 Parameter NUM_CH, default 4, number of single-wire sensor channels (1..16).
REQ-003 Parameter START_LOW_US, default 18000, host start pulse low time in µs.
REQ-004 Parameter BIT_THRESH_US, default 50, high-time threshold in µs; a longer high time decodes as bit 1.
REQ-005 Parameter TIMEOUT_US, default 200, maximum wait for any expected sensor edge.
REQ-006 Parameter POLL_MS, default 2000, idle gap between sweeps in auto mode.
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 auto_en  input  1  1 = free-running sweeps; 0 = sweep only on start.
REQ-010 start  input  1  single-cycle request for one sweep; ignored unless FSM is IDLE.
REQ-011 dht_in  input  NUM_CH  raw line levels, asynchronous.
REQ-012 dht_oe  output  NUM_CH  1 = pad drives line low; 0 = released (pull-up).
REQ-013 rd_valid  output  1  one-cycle pulse per completed channel transaction.
REQ-014 rd_ch  output  clog2(NUM_CH) (min 1)  channel of current result.
REQ-015 rd_data  output  32  bytes {hum_int, hum_dec, tmp_int, tmp_dec}, raw.
REQ-016 rd_status  output  2  00 OK, 01 checksum error, 10 timeout.
REQ-017 busy  output  1  high whenever FSM is not IDLE or POLL_WAIT.

Function
REQ-018 A prescaler SHALL generate a 1 µs single-cycle tick; all timers SHALL count ticks, saturate at the maximum count, and clear on every state change.
REQ-019 Each dht_in bit SHALL pass through a 2-flop synchroniser; edges SHALL be detected at clk rate on the selected channel only.
REQ-020 States: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, REPORT, POLL_WAIT.
REQ-021 IDLE -> START_LOW with ch=0 on start, or on auto_en=1.
REQ-022 START_LOW: dht_oe[ch]=1 for START_LOW_US, then -> RELEASE; all other dht_oe bits SHALL be 0 at all times.
REQ-023 RELEASE: wait for falling edge -> RESP_LOW; RESP_LOW: wait for rising edge -> RESP_HIGH; RESP_HIGH: wait for falling edge -> BIT_LOW with bit counter=0.
REQ-024 BIT_LOW: wait for rising edge -> BIT_HIGH; BIT_HIGH: on falling edge shift in (high_time > BIT_THRESH_US), MSB first, bit counter+1; after the 40th bit -> REPORT, else -> BIT_LOW.
REQ-025 In RELEASE through BIT_HIGH, a timer reaching TIMEOUT_US without the expected edge SHALL -> REPORT with status 10 and rd_data=0.
REQ-026 Checksum: (b39:32 + b31:24 + b23:16 + b15:8) mod 256 == b7:0 gives status 00, else 01; rd_data SHALL be bits 39:8 in both cases.
REQ-027 REPORT: rd_valid=1 for exactly one cycle with rd_ch, rd_data, rd_status; these SHALL hold until the next report.
REQ-028 After REPORT: if ch<NUM_CH-1, ch+1 -> START_LOW; else -> POLL_WAIT.
REQ-029 POLL_WAIT: if auto_en=1, wait POLL_MS*1000 ticks -> START_LOW with ch=0; if auto_en=0, -> IDLE immediately.
REQ-030 Deasserting auto_en mid-sweep SHALL let the current sweep complete.
REQ-031 A start pulse while not IDLE SHALL be dropped, not queued.
REQ-032 Edges on unselected channels SHALL have no effect.

Reset
REQ-033 On rst_n=0: state IDLE, ch=0, dht_oe=0, rd_valid=0, rd_ch=0, rd_data=0, rd_status=00, busy=0, timers and shift register cleared, synchronisers set to 1.
REQ-034 Reset asserted mid-transaction SHALL release every line within the same cycle and produce no report.

Verification
REQ-035 NUM_CH=2, start, both models send 0x37_00_19_00_50 -> two rd_valid pulses, ch 0 then 1, rd_data=0x37001900, status 00; dht_oe[0] low 18000 µs ±1.
REQ-036 Channel 1 model sends checksum 0x51 -> ch1 report status 01, rd_data=0x37001900.
REQ-037 Channel 0 model silent -> ch0 report status 10 about 200 µs after release, rd_data=0; ch1 still reports OK.
REQ-038 Bit high times of 49 µs and 71 µs -> decoded as 0 and 1 respectively.
REQ-039 auto_en=1, POLL_MS=2 -> second sweep's START_LOW begins 2000 µs ±1 after the last REPORT; start pulses during busy are ignored.
REQ-040 rst_n pulsed during BIT_HIGH on ch1 -> dht_oe=0, no rd_valid; next start begins at ch0.

Source files
------------

// File: rtl/dht_multi_reader.sv
// Multi-channel DHT11/DHT22 single-wire reader: sweeps NUM_CH sensors in order and
// reports one 32-bit reading plus status per channel.
module dht_multi_reader #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned POLL_MS       = 2000
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           auto_en,
    input  logic                                           start,
    input  logic [NUM_CH-1:0]                              dht_in,
    output logic [NUM_CH-1:0]                              dht_oe,
    output logic                                           rd_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    output logic [31:0]                                    rd_data,
    output logic [1:0]                                     rd_status,
    output logic                                           busy
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIV     = CLK_HZ / 1_000_000;
    localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned POLL_US = POLL_MS * 1000;
    localparam int unsigned MAX_A   = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int unsigned MAX_B   = (POLL_US > BIT_THRESH_US + 1) ? POLL_US : BIT_THRESH_US + 1;
    localparam int unsigned TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_REPORT, S_POLL_WAIT
    } state_t;

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [PS_W-1:0]    ps;
    logic               tick;
    logic [TMR_W-1:0]   tmr;
    logic [38:0]        sh;
    logic [5:0]         bit_cnt;
    logic [NUM_CH-1:0]  sync1, sync2;
    logic               sel_d;

    logic               sel, fall, rise, edge_hit, timed_out, bit_val, csum_ok;
    logic [39:0]        sh_nxt;
    logic [7:0]         csum;

    // 1 us tick from the system clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps   <= '0;
            tick <= 1'b0;
        end else if (ps == PS_W'(DIV - 1)) begin
            ps   <= '0;
            tick <= 1'b1;
        end else begin
            ps   <= ps + PS_W'(1);
            tick <= 1'b0;
        end
    end

    // Idle lines are pulled high, so the synchronisers reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            sel_d <= 1'b1;
        end else begin
            sync1 <= dht_in;
            sync2 <= sync1;
            sel_d <= sel;
        end
    end

    always_comb begin
        sel       = sync2[ch];
        fall      = sel_d & ~sel;
        rise      = ~sel_d & sel;
        edge_hit  = (state == S_RESP_LOW || state == S_BIT_LOW) ? rise : fall;
        timed_out = (tmr >= TMR_W'(TIMEOUT_US));
        bit_val   = (tmr > TMR_W'(BIT_THRESH_US));
        sh_nxt    = {sh, bit_val};
        csum      = 8'(sh_nxt[39:32] + sh_nxt[31:24] + sh_nxt[23:16] + sh_nxt[15:8]);
        csum_ok   = (csum == sh_nxt[7:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            dht_oe    <= '0;
            rd_valid  <= 1'b0;
            rd_ch     <= '0;
            rd_data   <= '0;
            rd_status <= 2'b00;
            busy      <= 1'b0;
            tmr       <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (tick && tmr != '1)
                tmr <= tmr + TMR_W'(1);
            case (state)
                S_IDLE: begin
                    if (start || auto_en) begin
                        state  <= S_START_LOW;
                        ch     <= '0;
                        dht_oe <= NUM_CH'(1);
                        busy   <= 1'b1;
                        tmr    <= '0;
                    end
                end
                S_START_LOW: begin
                    if (tmr >= TMR_W'(START_LOW_US)) begin
                        state  <= S_RELEASE;
                        dht_oe <= '0;
                        tmr    <= '0;
                    end
                end
                S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
                    if (edge_hit) begin
                        tmr <= '0;
                        case (state)
                            S_RELEASE:   state <= S_RESP_LOW;
                            S_RESP_LOW:  state <= S_RESP_HIGH;
                            S_RESP_HIGH: begin
                                state   <= S_BIT_LOW;
                                bit_cnt <= '0;
                            end
                            S_BIT_LOW:   state <= S_BIT_HIGH;
                            S_BIT_HIGH: begin
                                sh <= sh_nxt[38:0];
                                if (bit_cnt == 6'd39) begin
                                    state     <= S_REPORT;
                                    rd_valid  <= 1'b1;
                                    rd_ch     <= ch;
                                    rd_data   <= sh_nxt[39:8];
                                    rd_status <= csum_ok ? 2'b00 : 2'b01;
                                end else begin
                                    state   <= S_BIT_LOW;
                                    bit_cnt <= bit_cnt + 6'd1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (timed_out) begin
                        state     <= S_REPORT;
                        rd_valid  <= 1'b1;
                        rd_ch     <= ch;
                        rd_data   <= '0;
                        rd_status <= 2'b10;
                        tmr       <= '0;
                    end
                end
                S_REPORT: begin
                    tmr <= '0;
                    if (ch != CH_W'(NUM_CH - 1)) begin
                        state  <= S_START_LOW;
                        ch     <= ch + CH_W'(1);
                        dht_oe <= NUM_CH'(1) << (ch + CH_W'(1));
                    end else begin
                        state <= S_POLL_WAIT;
                        busy  <= 1'b0;
                    end
                end
                S_POLL_WAIT: begin
                    if (!auto_en) begin
                        state <= S_IDLE;
                        tmr   <= '0;
                    end else if (tmr >= TMR_W'(POLL_US)) begin
                        state  <= S_START_LOW;
                        ch     <= '0;
                        dht_oe <= NUM_CH'(1);
                        busy   <= 1'b1;
                        tmr    <= '0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    dht_oe <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_multi_reader.sv
// Directed bench for dht_multi_reader: two behavioural sensors on an open-drain bus,
// table of sweeps plus hand-written timing, auto-poll and reset sequences.
`timescale 1ns/1ps
module tb_dht_multi_reader;

    localparam int unsigned NUM_CH     = 2;
    localparam int          WAIT_LIMIT = 12000;

    logic        clk = 1'b0;
    logic        rst_n, auto_en, start;
    logic [1:0]  dht_in, dht_oe, mdl_low;
    logic        rd_valid;
    logic [0:0]  rd_ch;
    logic [31:0] rd_data;
    logic [1:0]  rd_status;
    logic        busy;

    dht_multi_reader #(
        .CLK_HZ(2_000_000), .NUM_CH(NUM_CH), .START_LOW_US(300),
        .BIT_THRESH_US(50), .TIMEOUT_US(200), .POLL_MS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .start(start),
        .dht_in(dht_in), .dht_oe(dht_oe), .rd_valid(rd_valid), .rd_ch(rd_ch),
        .rd_data(rd_data), .rd_status(rd_status), .busy(busy)
    );

    always #250 clk = ~clk;
    assign dht_in = ~(dht_oe | mdl_low);

    typedef struct {
        logic [0:0]  ch;
        logic [31:0] data;
        logic [1:0]  status;
        longint      t;
    } rep_t;
    rep_t rep_q[$];

    always @(negedge clk)
        if (rd_valid) rep_q.push_back('{rd_ch, rd_data, rd_status, longint'($time)});

    typedef struct {
        bit          silent0;
        logic [39:0] f0;
        int          h0_zero, h0_one;
        logic [39:0] f1;
        bit          noise;
        logic [31:0] d0;
        logic [1:0]  s0;
        logic [31:0] d1;
        logic [1:0]  s1;
    } vec_t;
    vec_t vecs[3];

    int     n_vec, n_err;
    longint t_assert, t_release, t_ref;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d ns, want %0d..%0d ns", name, act, lo, hi);
        end
    endtask

    task automatic us(input int d);
        #(d * 1000);
    endtask

    task automatic set_low(input int ch, input logic v, input bit noise);
        mdl_low[ch] = v;
        if (noise) mdl_low[1-ch] = ~v;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_reports(input int n, input string name);
        int k = 0;
        while (rep_q.size() < n && k < WAIT_LIMIT) begin
            @(negedge clk);
            k++;
        end
        check(name, 40'(rep_q.size()), 40'(n));
    endtask

    // Sensor model: waits for the host start pulse, then answers with a 40-bit frame
    task automatic sensor(input int ch, input bit silent, input logic [39:0] frame,
                          input int hi0, input int hi1, input bit noise, input int abort_bit);
        int k = 0;
        while (dht_oe[ch] !== 1'b1 && k < WAIT_LIMIT) begin @(negedge clk); k++; end
        check($sformatf("ch%0d start seen", ch), 40'(k < WAIT_LIMIT), 40'd1);
        t_assert = $time;
        check($sformatf("ch%0d other oe idle", ch), 40'(dht_oe[1-ch]), 40'd0);
        k = 0;
        while (dht_oe[ch] !== 1'b0 && k < WAIT_LIMIT) begin @(negedge clk); k++; end
        check($sformatf("ch%0d release seen", ch), 40'(k < WAIT_LIMIT), 40'd1);
        t_release = $time;
        if (silent) return;
        us(30);
        set_low(ch, 1'b1, noise); us(80);
        set_low(ch, 1'b0, noise); us(80);
        for (int b = 39; b >= 0; b--) begin
            set_low(ch, 1'b1, noise); us(12);
            set_low(ch, 1'b0, noise);
            if (39 - b == abort_bit) begin
                us(10);
                rst_n = 1'b0;
                #1;
                check("reset oe released", 40'(dht_oe), 40'd0);
                check("reset no valid", 40'(rd_valid), 40'd0);
                check("reset busy", 40'(busy), 40'd0);
                mdl_low = '0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            us(frame[b] ? hi1 : hi0);
        end
        set_low(ch, 1'b1, noise); us(12);
        mdl_low = '0;
    endtask

    initial begin
        #60ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{silent0: 1'b0, f0: 40'h37_00_19_00_50, h0_zero: 49, h0_one: 71,
                    f1: 40'h37_00_19_00_50, noise: 1'b0,
                    d0: 32'h37001900, s0: 2'b00, d1: 32'h37001900, s1: 2'b00};
        vecs[1] = '{silent0: 1'b1, f0: 40'h0, h0_zero: 26, h0_one: 70,
                    f1: 40'h37_00_19_00_51, noise: 1'b0,
                    d0: 32'h00000000, s0: 2'b10, d1: 32'h37001900, s1: 2'b01};
        vecs[2] = '{silent0: 1'b0, f0: 40'h00_FF_80_01_80, h0_zero: 26, h0_one: 70,
                    f1: 40'hAA_55_AA_55_FE, noise: 1'b1,
                    d0: 32'h00FF8001, s0: 2'b00, d1: 32'hAA55AA55, s1: 2'b00};

        n_vec = 0; n_err = 0;
        rst_n = 1'b0; auto_en = 1'b0; start = 1'b0; mdl_low = '0;
        repeat (4) @(negedge clk);
        check("rst dht_oe", 40'(dht_oe), 40'd0);
        check("rst rd_valid", 40'(rd_valid), 40'd0);
        check("rst rd_ch", 40'(rd_ch), 40'd0);
        check("rst rd_data", 40'(rd_data), 40'd0);
        check("rst rd_status", 40'(rd_status), 40'd0);
        check("rst busy", 40'(busy), 40'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of single manual sweeps
        for (int i = 0; i < 3; i++) begin
            rep_q.delete();
            pulse_start();
            @(negedge clk);
            check($sformatf("v%0d busy", i), 40'(busy), 40'd1);
            sensor(0, vecs[i].silent0, vecs[i].f0, vecs[i].h0_zero, vecs[i].h0_one, vecs[i].noise, -1);
            t_ref = t_release;
            if (i == 0) begin
                check_range("v0 start low width", t_release - t_assert, 299000, 301000);
                pulse_start();
            end
            sensor(1, 1'b0, vecs[i].f1, 26, 70, vecs[i].noise, -1);
            wait_reports(2, $sformatf("v%0d report count", i));
            if (rep_q.size() >= 2) begin
                check($sformatf("v%0d r0 ch", i), 40'(rep_q[0].ch), 40'd0);
                check($sformatf("v%0d r0 data", i), 40'(rep_q[0].data), 40'(vecs[i].d0));
                check($sformatf("v%0d r0 status", i), 40'(rep_q[0].status), 40'(vecs[i].s0));
                check($sformatf("v%0d r1 ch", i), 40'(rep_q[1].ch), 40'd1);
                check($sformatf("v%0d r1 data", i), 40'(rep_q[1].data), 40'(vecs[i].d1));
                check($sformatf("v%0d r1 status", i), 40'(rep_q[1].status), 40'(vecs[i].s1));
                if (i == 1)
                    check_range("v1 timeout latency", rep_q[0].t - t_ref, 199000, 202000);
            end
            us(50);
            check($sformatf("v%0d idle busy", i), 40'(busy), 40'd0);
            check($sformatf("v%0d idle oe", i), 40'(dht_oe), 40'd0);
            check($sformatf("v%0d no extra report", i), 40'(rep_q.size()), 40'd2);
        end

        // Auto mode: poll gap, then auto_en dropped mid-sweep lets the sweep finish
        rep_q.delete();
        @(negedge clk) auto_en = 1'b1;
        sensor(0, 1'b0, vecs[0].f1, 26, 70, 1'b0, -1);
        sensor(1, 1'b0, vecs[0].f1, 26, 70, 1'b0, -1);
        wait_reports(2, "auto sweep1 count");
        t_ref = (rep_q.size() >= 2) ? rep_q[1].t : 0;
        sensor(0, 1'b0, vecs[2].f0, 26, 70, 1'b0, -1);
        check_range("auto poll gap", t_assert - t_ref, 1999000, 2001000);
        auto_en = 1'b0;
        sensor(1, 1'b0, vecs[2].f1, 26, 70, 1'b0, -1);
        wait_reports(4, "auto sweep2 count");
        if (rep_q.size() >= 4) begin
            check("auto r2 data", 40'(rep_q[2].data), 40'h00FF8001);
            check("auto r3 ch", 40'(rep_q[3].ch), 40'd1);
            check("auto r3 data", 40'(rep_q[3].data), 40'hAA55AA55);
        end
        begin
            logic [1:0] oe_seen = '0;
            for (int k = 0; k < 4200; k++) begin
                @(negedge clk);
                oe_seen |= dht_oe;
            end
            check("auto stopped oe", 40'(oe_seen), 40'd0);
        end
        check("auto stopped reports", 40'(rep_q.size()), 40'd4);

        // Reset during a bit-high phase on channel 1
        rep_q.delete();
        pulse_start();
        sensor(0, 1'b0, vecs[0].f0, 49, 71, 1'b0, -1);
        sensor(1, 1'b0, vecs[0].f1, 26, 70, 1'b0, 5);
        us(20);
        check("reset report count", 40'(rep_q.size()), 40'd1);
        check("post reset oe", 40'(dht_oe), 40'd0);
        pulse_start();
        begin
            int k = 0;
            while (dht_oe === 2'b00 && k < 100) begin @(negedge clk); k++; end
        end
        check("restart at ch0", 40'(dht_oe), 40'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
